lfsr_checker: RTL and testbench

LFSR_CHECKER -- requirements
Module: lfsr_checker

---
 rtl/lfsr_checker.sv | 118 +++++++++++
 tb/tb_lfsr_checker.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// Checks a received 32-bit XNOR-LFSR word stream (taps 32,22,2,1), declares lock after
// a seed plus LOCK_CNT consecutive matches, and counts mismatches while locked.
module lfsr_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_THR = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  input  logic [31:0]      in_data_i,
  input  logic             clr_i,
  output logic             locked_o,
  output logic             err_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [1:0]       state_o
);

  // Handshake: in_valid_i qualifies in_data_i for exactly one cycle; there is no
  // backpressure, so every valid word is consumed on the rising edge it is seen.

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0]       LOCK_LAST = 8'(LOCK_CNT - 1);
  localparam logic [7:0]       LOSS_LAST = 8'(LOSS_THR - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], ~^{s[31], s[21], s[1], s[0]}};
  endfunction

  state_t      state;
  logic [31:0] ref_q;
  logic [7:0]  match_cnt;
  logic [7:0]  miss_cnt;

  logic [31:0] ref_next;
  logic        word_match;
  logic        word_ones;

  assign ref_next   = lfsr_step(ref_q);
  assign word_match = (in_data_i == ref_next);
  assign word_ones  = &in_data_i;
  assign state_o    = state;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= SEED;
      ref_q     <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked_o  <= 1'b0;
      err_o     <= 1'b0;
      err_cnt_o <= '0;
    end else begin
      err_o <= 1'b0;

      // Clear wins over a coincident increment and touches nothing else.
      if (clr_i) begin
        err_cnt_o <= '0;
      end else if (in_valid_i && state == LOCKED && !word_match && err_cnt_o != '1) begin
        err_cnt_o <= err_cnt_o + CNT_ONE;
      end

      if (in_valid_i) begin
        case (state)
          SEED: begin
            // The all-ones word is the XNOR lock-up state and cannot start a sequence.
            if (!word_ones) begin
              ref_q     <= in_data_i;
              match_cnt <= '0;
              state     <= HUNT;
            end
          end
          HUNT: begin
            if (word_match) begin
              ref_q     <= in_data_i;
              match_cnt <= match_cnt + 8'd1;
              if (match_cnt == LOCK_LAST) begin
                state    <= LOCKED;
                miss_cnt <= '0;
                locked_o <= 1'b1;
              end
            end else if (word_ones) begin
              state <= SEED;
            end else begin
              ref_q     <= in_data_i;
              match_cnt <= '0;
            end
          end
          LOCKED: begin
            // Flywheel: the reference free-runs and is never reloaded from the line.
            ref_q <= ref_next;
            if (word_match) begin
              miss_cnt <= '0;
            end else begin
              err_o    <= 1'b1;
              miss_cnt <= miss_cnt + 8'd1;
              if (miss_cnt == LOSS_LAST) begin
                state    <= SEED;
                locked_o <= 1'b0;
              end
            end
          end
          default: begin
            state    <= SEED;
            locked_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: drivers push hand-computed expected responses,
// a negedge monitor pops and compares them against a default and a saturating instance.
module tb_lfsr_checker;

  localparam int W = 18;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_a, valid_b, clr;
  logic [31:0] data;

  logic        locked_a, err_a, locked_b, err_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;
  logic [1:0]  st_a, st_b;

  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];
  int           errors = 0;
  int           checks = 0;
  logic [31:0]  seq[32];

  always #5 clk = ~clk;

  lfsr_checker dut_a (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(valid_a), .in_data_i(data), .clr_i(clr),
    .locked_o(locked_a), .err_o(err_a), .err_cnt_o(cnt_a), .state_o(st_a)
  );

  lfsr_checker #(.LOCK_CNT(4), .LOSS_THR(32), .CNT_W(4)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(valid_b), .in_data_i(data), .clr_i(clr),
    .locked_o(locked_b), .err_o(err_b), .err_cnt_o(cnt_b), .state_o(st_b)
  );

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], ~^{s[31], s[21], s[1], s[0]}};
  endfunction

  task automatic seq_from(input logic [31:0] seed);
    seq[0] = seed;
    for (int i = 1; i < 32; i++) seq[i] = lfsr_step(seq[i-1]);
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got locked=%0b err=%0b cnt=%0d, expected locked=%0b err=%0b cnt=%0d",
               name, act[17], act[16], act[15:0], exp[17], exp[16], exp[15:0]);
    end
  endtask

  // Scoreboard monitor: one expected entry per driven cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_a_q.size() > 0) check("resp_a", {locked_a, err_a, cnt_a}, exp_a_q.pop_front());
    if (exp_b_q.size() > 0) check("resp_b", {locked_b, err_b, 12'b0, cnt_b}, exp_b_q.pop_front());
  end

  task automatic cyc_a(input logic v, input logic [31:0] d, input logic c,
                       input logic el, input logic ee, input int ec);
    valid_a = v; valid_b = 1'b0; data = d; clr = c;
    @(posedge clk); #1;
    valid_a = 1'b0; clr = 1'b0;
    exp_a_q.push_back({el, ee, 16'(ec)});
  endtask

  task automatic cyc_b(input logic v, input logic [31:0] d, input logic c,
                       input logic el, input logic ee, input int ec);
    valid_a = 1'b0; valid_b = v; data = d; clr = c;
    @(posedge clk); #1;
    valid_b = 1'b0; clr = 1'b0;
    exp_b_q.push_back({el, ee, 16'(ec)});
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("reset_a", {locked_a, err_a, cnt_a}, '0);
    check("reset_b", {locked_b, err_b, 12'b0, cnt_b}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; valid_a = 1'b0; valid_b = 1'b0; clr = 1'b0; data = '0;
    do_reset();

    // Idle words change nothing.
    cyc_a(0, 32'hAE1F_B42C, 0, 0, 0, 0);
    cyc_a(0, 32'h5C3F_6858, 0, 0, 0, 0);

    // Lock: seed plus four matches, with an idle gap mid-hunt.
    seq_from(32'hAE1F_B42C);
    cyc_a(1, seq[0], 0, 0, 0, 0);
    cyc_a(1, 32'h5C3F_6858, 0, 0, 0, 0);
    cyc_a(1, seq[2], 0, 0, 0, 0);
    cyc_a(0, seq[3], 0, 0, 0, 0);
    cyc_a(1, seq[3], 0, 0, 0, 0);
    cyc_a(1, seq[4], 0, 1, 0, 0);

    // Single error, then idle and flywheel continuation.
    cyc_a(1, seq[5] ^ 32'h1, 0, 1, 1, 1);
    cyc_a(0, seq[6], 0, 1, 0, 1);
    cyc_a(1, seq[6], 0, 1, 0, 1);
    cyc_a(1, seq[7], 0, 1, 0, 1);

    // Clear, then eight misses lose lock.
    cyc_a(0, seq[8], 1, 1, 0, 0);
    for (int m = 1; m <= 8; m++) cyc_a(1, seq[7+m] ^ 32'h8000_0000, 0, (m < 8), 1, m);

    // Relock on a new seed; counter keeps its value.
    seq_from(32'h1234_5678);
    for (int i = 0; i < 4; i++) cyc_a(1, seq[i], 0, 0, 0, 8);
    cyc_a(1, seq[4], 0, 1, 0, 8);

    // Clear coincident with an error, then lose lock again.
    cyc_a(1, seq[5] ^ 32'h1, 1, 1, 1, 0);
    for (int m = 2; m <= 8; m++) cyc_a(1, seq[4+m] ^ 32'h1, 0, (m < 8), 1, m - 1);

    // Reset mid-hunt abandons progress.
    seq_from(32'hDEAD_BEEF);
    cyc_a(1, seq[0], 0, 0, 0, 7);
    cyc_a(1, seq[1], 0, 0, 0, 7);
    cyc_a(1, seq[2], 0, 0, 0, 7);
    do_reset();
    for (int i = 3; i < 7; i++) cyc_a(1, seq[i], 0, 0, 0, 0);
    cyc_a(1, seq[7], 0, 1, 0, 0);

    // Lock-up word is ignored in SEED.
    do_reset();
    for (int i = 0; i < 3; i++) cyc_a(1, 32'hFFFF_FFFF, 0, 0, 0, 0);
    seq_from(32'h0000_0001);
    for (int i = 0; i < 4; i++) cyc_a(1, seq[i], 0, 0, 0, 0);
    cyc_a(1, seq[4], 0, 1, 0, 0);

    // Saturation on the 4-bit counter instance.
    do_reset();
    seq_from(32'hCAFE_0001);
    for (int i = 0; i < 4; i++) cyc_b(1, seq[i], 0, 0, 0, 0);
    cyc_b(1, seq[4], 0, 1, 0, 0);
    for (int m = 1; m <= 20; m++) cyc_b(1, seq[4+m] ^ 32'h1, 0, 1, 1, (m < 15) ? m : 15);
    cyc_b(1, seq[25], 0, 1, 0, 15);
    cyc_b(0, seq[26], 1, 1, 0, 0);

    @(negedge clk);
    @(negedge clk);
    if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d/%0d pending entries, expected 0/0", exp_a_q.size(), exp_b_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
